tone_decoder: RTL and testbench

Receive-side counterpart of the beeper tone generator. Samples an incoming square-wave tone (the beeper line looped back, or a comparator-squared microphone), measures its period in clock cycles, and maps it back to the 5-bit note index used by the tone tables. After a configurable number of consistent periods it reports a note change, and it reports silence after a timeout. Used for self-test of the music player and for note-recognition demos.

---
 rtl/tone_pkg.sv | 25 ++
 rtl/tone_lookup.sv | 76 +++++++
 rtl/tone_decoder.sv | 207 ++++++++++++++++++++
 tb/tb_tone_decoder.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
// Shared tone definitions: note count, per-note period table (clock cycles
// per tone period, index 1 = lowest pitch), note index type and decoder FSM
// states. Index 0 of the table stands for "silence" and holds no period.
package tone_pkg;

    localparam int NOTES = 21;

    typedef logic [4:0] note_t;

    typedef enum logic [1:0] {
        ST_SILENT  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOOKUP  = 2'd2
    } state_t;

    // Neighbouring entries are spaced far enough apart that their tolerance
    // windows (+/- entry >> 4) leave gaps between them.
    localparam int unsigned TONE_CYCLE [0:NOTES] = '{
        0,
        654, 569, 495, 430, 374, 325, 283, 246, 214, 186,
        162, 141, 123, 107,  93,  81,  70,  61,  53,  46,
        40
    };

endpackage

// File: rtl/tone_lookup.sv
// Sequential period-to-note table scan. A start pulse latches the period;
// entries 1..NOTES are then compared one per cycle and the first entry whose
// tolerance window contains the period wins. o_done pulses for one cycle with
// the result (0 = no match). i_abort cancels a scan in progress.
module tone_lookup
    import tone_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int TIMEOUT   = 60000,
    parameter int TOL_SHIFT = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [WIDTH-1:0] i_period,
    output logic             o_done,
    output note_t            o_result
);

    logic             r_busy;
    logic             r_done;
    note_t            r_idx;
    note_t            r_res;
    logic [WIDTH-1:0] r_per;

    logic [WIDTH:0]   w_per;
    logic [WIDTH:0]   w_ref;
    logic [WIDTH:0]   w_tol;
    logic [WIDTH:0]   w_diff;
    logic             w_match;

    // Compare the latched period against the current table entry; one extra
    // bit keeps the absolute difference from wrapping.
    always_comb begin
        w_per   = {1'b0, r_per};
        w_ref   = (WIDTH+1)'(TONE_CYCLE[r_idx]);
        w_tol   = w_ref >> TOL_SHIFT;
        w_diff  = (w_per >= w_ref) ? (w_per - w_ref) : (w_ref - w_per);
        w_match = (r_per != WIDTH'(TIMEOUT)) && (w_diff <= w_tol);
    end

    // Scan sequencer: latch on start, walk the table, flag completion.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_idx  <= note_t'(1);
            r_res  <= '0;
            r_per  <= '0;
        end else begin
            r_done <= 1'b0;
            if (i_abort) begin
                r_busy <= 1'b0;
            end else if (i_start) begin
                r_busy <= 1'b1;
                r_idx  <= note_t'(1);
                r_res  <= '0;
                r_per  <= i_period;
            end else if (r_busy) begin
                if (r_res == '0 && w_match)
                    r_res <= r_idx;
                if (r_idx == note_t'(NOTES)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end else begin
                    r_idx <= r_idx + note_t'(1);
                end
            end
        end
    end

    assign o_done   = r_done;
    assign o_result = r_res;

endmodule

// File: rtl/tone_decoder.sv
// Square-wave tone decoder: synchronizes tone_in, measures the rising-edge
// period, maps it to a note index through tone_lookup and reports a note
// change after MATCH_CNT consistent lookups, or silence after TIMEOUT cycles
// without an edge.
// Optional build macro TONE_DEC_DUTY_EN: also measures high time and rejects
// periods whose duty cycle lies outside 25 %..75 %.
module tone_decoder
    import tone_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int TIMEOUT   = 60000,
    parameter int MATCH_CNT = 3,
    parameter int TOL_SHIFT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tone_in,
    output note_t            note,
    output logic             note_valid,
    output logic [WIDTH-1:0] period
);

    localparam int MW = $clog2(MATCH_CNT + 1);

    logic             r_s1, r_s2, r_s3;
    logic [WIDTH-1:0] r_pcnt;
    logic             r_armed;
    state_t           r_state;
    note_t            r_cand;
    logic [MW-1:0]    r_mcnt;

    logic             w_edge;
    logic             w_sat;
    state_t           w_next;
    logic             w_arm, w_start, w_abort, w_commit, w_silence;
    logic             w_lk_done;
    note_t            w_lk_result;
    note_t            w_result;
    note_t            w_cand_nx;
    logic [MW-1:0]    w_mcnt_nx;
    note_t            w_note_nx;
    logic             w_nv_nx;

    assign w_edge = r_s2 & ~r_s3;
    assign w_sat  = (r_pcnt == WIDTH'(TIMEOUT));

    // Two-flop synchronizer plus one delay flop for rising-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= tone_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // Period counter: restarts at 1 on every edge, saturates at TIMEOUT.
    always_ff @(posedge clk) begin
        if (rst)
            r_pcnt <= '0;
        else if (w_edge)
            r_pcnt <= WIDTH'(1);
        else if (!w_sat)
            r_pcnt <= r_pcnt + WIDTH'(1);
    end

`ifdef TONE_DEC_DUTY_EN
    logic [WIDTH-1:0] r_hcnt;
    logic             r_duty_ok;
    logic [WIDTH+1:0] w_h4, w_p1, w_p3;

    assign w_h4 = {r_hcnt, 2'b00};
    assign w_p1 = {2'b00, r_pcnt};
    assign w_p3 = w_p1 + {1'b0, r_pcnt, 1'b0};

    // High-time counter and duty window check latched with the period.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hcnt    <= '0;
            r_duty_ok <= 1'b0;
        end else begin
            if (w_edge)
                r_hcnt <= WIDTH'(1);
            else if (r_s2 && r_hcnt != WIDTH'(TIMEOUT))
                r_hcnt <= r_hcnt + WIDTH'(1);
            if (w_start)
                r_duty_ok <= (w_h4 >= w_p1) && (w_h4 <= w_p3);
        end
    end

    assign w_result = r_duty_ok ? w_lk_result : '0;
`else
    assign w_result = w_lk_result;
`endif

    tone_lookup #(
        .WIDTH     (WIDTH),
        .TIMEOUT   (TIMEOUT),
        .TOL_SHIFT (TOL_SHIFT)
    ) u_lookup (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_start  (w_start),
        .i_abort  (w_abort),
        .i_period (r_pcnt),
        .o_done   (w_lk_done),
        .o_result (w_lk_result)
    );

    // Next-state decode and candidate filter update.
    always_comb begin
        w_next    = r_state;
        w_arm     = 1'b0;
        w_start   = 1'b0;
        w_abort   = 1'b0;
        w_commit  = 1'b0;
        w_silence = 1'b0;
        w_cand_nx = r_cand;
        w_mcnt_nx = r_mcnt;
        w_note_nx = note;
        w_nv_nx   = 1'b0;

        case (r_state)
            ST_SILENT: begin
                if (w_edge) begin
                    w_arm  = 1'b1;
                    w_next = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                if (w_edge) begin
                    if (r_armed) begin
                        w_start = 1'b1;
                        w_next  = ST_LOOKUP;
                    end else begin
                        w_arm = 1'b1;
                    end
                end else if (w_sat) begin
                    w_silence = 1'b1;
                    w_next    = ST_SILENT;
                end
            end
            ST_LOOKUP: begin
                // An edge here means the period is too short to classify.
                if (w_edge) begin
                    w_abort = 1'b1;
                    w_next  = ST_MEASURE;
                end else if (w_lk_done) begin
                    w_commit = 1'b1;
                    w_next   = ST_MEASURE;
                end
            end
            default: w_next = ST_SILENT;
        endcase

        if (w_silence) begin
            w_cand_nx = '0;
            w_mcnt_nx = '0;
            w_note_nx = '0;
            w_nv_nx   = (note != '0);
        end else if (w_abort) begin
            w_cand_nx = '0;
            w_mcnt_nx = '0;
        end else if (w_commit) begin
            if (w_result == r_cand) begin
                if (r_mcnt != MW'(MATCH_CNT))
                    w_mcnt_nx = r_mcnt + MW'(1);
            end else begin
                w_cand_nx = w_result;
                w_mcnt_nx = MW'(1);
            end
            if (w_mcnt_nx == MW'(MATCH_CNT) && w_cand_nx != note) begin
                w_note_nx = w_cand_nx;
                w_nv_nx   = 1'b1;
            end
        end
    end

    // State, arm flag, filter and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_SILENT;
            r_armed    <= 1'b0;
            r_cand     <= '0;
            r_mcnt     <= '0;
            note       <= '0;
            note_valid <= 1'b0;
            period     <= '0;
        end else begin
            r_state <= w_next;
            if (w_arm)
                r_armed <= 1'b1;
            else if (w_silence)
                r_armed <= 1'b0;
            r_cand     <= w_cand_nx;
            r_mcnt     <= w_mcnt_nx;
            note       <= w_note_nx;
            note_valid <= w_nv_nx;
            if (w_start)
                period <= r_pcnt;
        end
    end

endmodule

// File: tb/tb_tone_decoder.sv
// Scoreboard bench for tone_decoder. Each scenario is a list of rising edges
// (gap to next edge, high time); an event-level reference model walks the
// list and queues the expected note changes, then the list is driven onto
// tone_in while a monitor pops the queue on every note_valid pulse.
// Honours TONE_DEC_DUTY_EN for the duty-cycle scenarios.
module tb_tone_decoder;
    import tone_pkg::*;

    localparam int WIDTH = 16;
    localparam int TO    = 1000;
    localparam int MATCH = 3;
    localparam int TOL   = 4;
    localparam int MINP  = NOTES + 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             tone_in;
    note_t            note;
    logic             note_valid;
    logic [WIDTH-1:0] period;

    tone_decoder #(
        .WIDTH     (WIDTH),
        .TIMEOUT   (TO),
        .MATCH_CNT (MATCH),
        .TOL_SHIFT (TOL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tone_in    (tone_in),
        .note       (note),
        .note_valid (note_valid),
        .period     (period)
    );

    always #5 clk = ~clk;

    typedef struct {
        int n;
        int p;
    } exp_t;

    exp_t exp_q[$];
    int   gq[$];
    int   hq[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   m_note = 0, m_cand = 0, m_mcnt = 0, m_period = 0;
    bit   mon_mcnt = 0;
    int   mcnt_max = 0;

    function automatic void check(string nm, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endfunction

    // Reference: first table entry whose tolerance window holds p.
    function automatic int ref_lookup(int p);
        if (p == TO) return 0;
        for (int i = 1; i <= NOTES; i++) begin
            int t = int'(TONE_CYCLE[i]);
            int d = (p > t) ? p - t : t - p;
            if (d <= (t >> TOL)) return i;
        end
        return 0;
    endfunction

    function automatic void m_commit(int res);
        if (res == m_cand) begin
            if (m_mcnt < MATCH) m_mcnt++;
        end else begin
            m_cand = res;
            m_mcnt = 1;
        end
        if (m_mcnt == MATCH && m_cand != m_note) begin
            m_note = m_cand;
            exp_q.push_back('{m_note, m_period});
        end
    endfunction

    function automatic void m_silence();
        if (m_note != 0) exp_q.push_back('{0, m_period});
        m_note = 0;
        m_cand = 0;
        m_mcnt = 0;
    endfunction

    task automatic add_edges(input int cnt, input int gap, input int high);
        for (int i = 0; i < cnt; i++) begin
            gq.push_back(gap);
            hq.push_back(high);
        end
    endtask

    task automatic drive(input logic v, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            tone_in = v;
        end
    endtask

    // Run the edge list: model first (queue expectations), then drive.
    task automatic run_scenario(input string name, input int tail, input bit rst_end);
        int  n;
        bit  armed;
        bit  inl;
        int  res;
        bit  last;
        n = gq.size();
        gq[n-1] = tail;
        armed = 0;
        inl = 0;
        res = 0;
        for (int k = 0; k < n; k++) begin
            last = (k == n - 1);
            if (!armed) begin
                armed = 1;
            end else if (inl) begin
                m_cand = 0;
                m_mcnt = 0;
                inl = 0;
            end else begin
                m_period = gq[k-1];
                res = ref_lookup(gq[k-1]);
`ifdef TONE_DEC_DUTY_EN
                if (4 * hq[k-1] < gq[k-1] || 4 * hq[k-1] > 3 * gq[k-1]) res = 0;
`endif
                inl = 1;
            end
            if (inl && (last ? !rst_end : gq[k] >= MINP)) begin
                m_commit(res);
                inl = 0;
            end
            if (!(last && rst_end) && gq[k] > TO) begin
                m_silence();
                armed = 0;
            end
        end

        for (int k = 0; k < n; k++) begin
            if (k == n - 1 && rst_end) begin
                drive(1'b1, 10);
            end else begin
                drive(1'b1, hq[k]);
                drive(1'b0, gq[k] - hq[k]);
            end
        end

        if (rst_end) begin
            @(negedge clk);
            rst = 1'b1;
            tone_in = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            m_note = 0; m_cand = 0; m_mcnt = 0; m_period = 0;
            #1;
            check({name, "_rst_note"}, int'(note), 0);
            check({name, "_rst_period"}, int'(period), 0);
            check({name, "_rst_valid"}, int'(note_valid), 0);
        end
        repeat (30) @(negedge clk);
        #1;
        check({name, "_queue_empty"}, exp_q.size(), 0);
        check({name, "_note_end"}, int'(note), m_note);
        check({name, "_state_silent"}, int'(dut.r_state), int'(ST_SILENT));
        check({name, "_period_end"}, int'(period), m_period);
        exp_q.delete();
        gq.delete();
        hq.delete();
    endtask

    // Monitor: every note_valid pulse must match the next queued change.
    always @(negedge clk) begin
        if (mon_mcnt && int'(dut.r_mcnt) > mcnt_max) mcnt_max = int'(dut.r_mcnt);
        if (note_valid) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_note_valid: got note %0d, expected no pulse", note);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("pulse_note", int'(note), e.n);
                check("pulse_period", int'(period), e.p);
            end
        end
    end

    initial begin
        int t8;
        t8 = int'(TONE_CYCLE[8]);
        rst = 1'b1;
        tone_in = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_note", int'(note), 0);
        check("reset_valid", int'(note_valid), 0);
        check("reset_period", int'(period), 0);
        rst = 1'b0;

        add_edges(6, t8, t8 / 2);
        run_scenario("note8", TO + 60, 0);

        add_edges(6, t8 + (t8 >> 4), t8 / 2);
        run_scenario("tol_edge", TO + 60, 0);

        add_edges(6, t8 + (t8 >> 4) + 2, t8 / 2);
        run_scenario("between", TO + 60, 0);

        mon_mcnt = 1;
        mcnt_max = 0;
        for (int i = 0; i < 8; i++) begin
            add_edges(1, int'(TONE_CYCLE[5]), int'(TONE_CYCLE[5]) / 2);
            add_edges(1, int'(TONE_CYCLE[6]), int'(TONE_CYCLE[6]) / 2);
        end
        run_scenario("alternate", TO + 60, 0);
        mon_mcnt = 0;
        check("alternate_mcnt_max", mcnt_max, 1);

        add_edges(11, 10, 5);
        run_scenario("short", TO + 60, 0);

        add_edges(5, t8, t8 / 2);
        add_edges(1, MINP - 1, (MINP - 1) / 2);
        add_edges(1, MINP, MINP / 2);
        add_edges(4, t8, t8 / 2);
        run_scenario("min_period", TO + 60, 0);

        add_edges(4, t8, t8 / 2);
        add_edges(1, TO, TO / 2);
        add_edges(5, t8, t8 / 2);
        run_scenario("edge_at_timeout", TO + 60, 0);

        add_edges(4, t8, t8 / 2);
        add_edges(1, TO + 1, TO / 2);
        add_edges(5, t8, t8 / 2);
        run_scenario("past_timeout", TO + 60, 0);

        add_edges(6, t8, t8 / 2);
        run_scenario("mid_lookup_rst", 20, 1);

        for (int s = 0; s < 10; s++) begin
            int nt, t, cnt, mode, g, tol;
            nt  = int'($urandom_range(1, NOTES));
            t   = int'(TONE_CYCLE[nt]);
            tol = t >> TOL;
            cnt = int'($urandom_range(1, 5));
            for (int c = 0; c < cnt; c++) begin
                mode = int'($urandom_range(0, 9));
                if (mode < 7)
                    g = t + int'($urandom_range(0, 2 * tol)) - tol;
                else if (mode < 9)
                    g = int'($urandom_range(MINP, 700));
                else
                    g = int'($urandom_range(MINP - 4, MINP + 3));
                add_edges(1, g, g / 2);
            end
        end
        run_scenario("random", TO + 60, 0);

`ifdef TONE_DEC_DUTY_EN
        add_edges(6, int'(TONE_CYCLE[3]), int'(TONE_CYCLE[3]) / 10);
        run_scenario("duty10", TO + 60, 0);
        add_edges(6, int'(TONE_CYCLE[3]), int'(TONE_CYCLE[3]) / 2);
        run_scenario("duty50", TO + 60, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
